// File: rtl/bsg_mem_1r1w_sync_stream_reader.sv
//------------------------------------------------------------------------------
// bsg_mem_1r1w_sync_stream_reader: burst read master for bsg_mem_1r1w_sync,
// streaming words out on valid/yumi. Option: BSG_MEM_STREAM_READER_COLLISION_STALL_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_mem_1r1w_sync_stream_reader #(
   parameter int width_p       = 8,
   parameter int els_p         = 8,
   parameter int len_width_p   = 16,
   parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     cmd_v_i,
   input  logic [addr_width_lp-1:0] cmd_addr_i,
   input  logic [len_width_p-1:0]   cmd_len_i,
   output logic                     cmd_ready_o,
`ifdef BSG_MEM_STREAM_READER_COLLISION_STALL_EN
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
`endif
   output logic                     r_v_o,
   output logic [addr_width_lp-1:0] r_addr_o,
   input  logic [width_p-1:0]       r_data_i,
   output logic                     data_v_o,
   output logic [width_p-1:0]       data_o,
   output logic                     data_last_o,
   input  logic                     data_yumi_i,
   output logic                     busy_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [addr_width_lp-1:0] cur_addr_q, cur_addr_d;
   logic [len_width_p-1:0]   remaining_q, remaining_d;
   logic                     inflight_q, inflight_d;
   logic                     inflight_last_q, inflight_last_d;
   logic [width_p:0]         fifo_q [2];
   logic [width_p:0]         fifo_d [2];
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic [1:0]               count_q, count_d;

   logic                     pop;
   logic                     room;
   logic                     issue;
   logic                     stall;
   logic [2:0]               projected;

   assign pop       = data_yumi_i & (count_q != 2'd0);
   // Slots committed after this cycle: buffered + in flight - leaving now.
   assign projected = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign room      = (projected < 3'd2);

`ifdef BSG_MEM_STREAM_READER_COLLISION_STALL_EN
   assign stall = w_v_i & (w_addr_i == cur_addr_q);
`else
   assign stall = 1'b0;
`endif

   assign issue = (state_q == RUN) & (remaining_q != '0) & room & ~stall;

   always_comb begin
      state_d         = state_q;
      cur_addr_d      = cur_addr_q;
      remaining_d     = remaining_q;
      inflight_d      = 1'b0;
      inflight_last_d = inflight_last_q;
      fifo_d          = fifo_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};

      if ((state_q == IDLE) && cmd_v_i && (cmd_len_i != '0)) begin
         state_d     = RUN;
         cur_addr_d  = cmd_addr_i;
         remaining_d = cmd_len_i;
      end

      if (issue) begin
         cur_addr_d      = (cur_addr_q == addr_width_lp'(els_p - 1))
                           ? '0 : cur_addr_q + addr_width_lp'(1);
         remaining_d     = remaining_q - len_width_p'(1);
         inflight_d      = 1'b1;
         inflight_last_d = (remaining_q == len_width_p'(1));
         if (remaining_q == len_width_p'(1)) begin
            state_d = IDLE;
         end
      end

      // Memory output is only valid this one cycle, so it is always taken.
      if (inflight_q) begin
         fifo_d[wr_ptr_q] = {inflight_last_q, r_data_i};
         wr_ptr_d         = ~wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q         <= IDLE;
         cur_addr_q      <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_q[0]       <= '0;
         fifo_q[1]       <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         state_q         <= state_d;
         cur_addr_q      <= cur_addr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fifo_q[0]       <= fifo_d[0];
         fifo_q[1]       <= fifo_d[1];
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign r_v_o       = issue;
   assign r_addr_o    = cur_addr_q;
   assign data_v_o    = (count_q != 2'd0);
   assign data_o      = fifo_q[rd_ptr_q][width_p-1:0];
   assign data_last_o = fifo_q[rd_ptr_q][width_p];
   assign busy_o      = (state_q == RUN) | inflight_q | (count_q != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_bsg_mem_1r1w_sync_stream_reader.sv
//------------------------------------------------------------------------------
// tb_bsg_mem_1r1w_sync_stream_reader: directed + random bursts against a
// queue-based model of the read stream. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_mem_1r1w_sync_stream_reader;

   localparam int W   = 8;
   localparam int ELS = 8;
   localparam int AW  = 3;
   localparam int LW  = 16;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          cmd_v_i = 1'b0;
   logic [AW-1:0] cmd_addr_i = '0;
   logic [LW-1:0] cmd_len_i = '0;
   logic          cmd_ready_o;
   logic          w_v_i = 1'b0;
   logic [AW-1:0] w_addr_i = '0;
   logic          r_v_o;
   logic [AW-1:0] r_addr_o;
   logic [W-1:0]  r_data_i = '0;
   logic          data_v_o;
   logic [W-1:0]  data_o;
   logic          data_last_o;
   logic          data_yumi_i = 1'b0;
   logic          busy_o;

   bsg_mem_1r1w_sync_stream_reader #(
      .width_p    (W),
      .els_p      (ELS),
      .len_width_p(LW)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .cmd_v_i    (cmd_v_i),
      .cmd_addr_i (cmd_addr_i),
      .cmd_len_i  (cmd_len_i),
      .cmd_ready_o(cmd_ready_o),
`ifdef BSG_MEM_STREAM_READER_COLLISION_STALL_EN
      .w_v_i      (w_v_i),
      .w_addr_i   (w_addr_i),
`endif
      .r_v_o      (r_v_o),
      .r_addr_o   (r_addr_o),
      .r_data_i   (r_data_i),
      .data_v_o   (data_v_o),
      .data_o     (data_o),
      .data_last_o(data_last_o),
      .data_yumi_i(data_yumi_i),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous-read memory with a fixed 1-cycle latency.
   logic [W-1:0] mem [ELS];
   always @(posedge clk_i) begin
      if (r_v_o) r_data_i <= mem[r_addr_o];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: pending read addresses, expected stream words, issue/consume counts.
   int         aq[$];
   logic [W:0] dq[$];
   int         issued_total = 0;
   int         consumed     = 0;
   bit         inflight_m   = 0;
   bit         coll_v       = 0;
   int         coll_addr    = 0;

   task automatic model_clear();
      aq.delete();
      dq.delete();
      issued_total = 0;
      consumed     = 0;
      inflight_m   = 0;
   endtask

   task automatic step(input bit cv, input int ca, input int cl, input bit yen);
      int  occ;
      bit  ready_m, y, exp_rv, coll;
      @(negedge clk_i);
      y           = yen && data_v_o;
      data_yumi_i = y;
      cmd_v_i     = cv;
      cmd_addr_i  = AW'(ca);
      cmd_len_i   = LW'(cl);
      w_v_i       = coll_v;
      w_addr_i    = AW'(coll_addr);
      #1;
      occ     = issued_total - int'(inflight_m) - consumed;
      ready_m = (aq.size() == 0);
      check("data_v", data_v_o, occ > 0);
      check("cmd_ready", cmd_ready_o, ready_m);
      check("busy", busy_o, (aq.size() != 0) || (issued_total - consumed > 0));
      coll = 1'b0;
`ifdef BSG_MEM_STREAM_READER_COLLISION_STALL_EN
      if (aq.size() != 0) coll = coll_v && (coll_addr == aq[0]);
`endif
      exp_rv = (aq.size() != 0) && (occ + int'(inflight_m) - int'(y && occ > 0) < 2) && !coll;
      check("r_v", r_v_o, exp_rv);
      if (exp_rv) begin
         check("r_addr", r_addr_o, aq[0]);
         void'(aq.pop_front());
      end
      if (y && occ > 0) begin
         check("data", data_o, dq[0][W-1:0]);
         check("last", data_last_o, dq[0][W]);
         void'(dq.pop_front());
         consumed++;
      end
      if (cv && ready_m) begin
         for (int i = 0; i < cl; i++) begin
            aq.push_back((ca + i) % ELS);
            dq.push_back({(i == cl - 1), mem[(ca + i) % ELS]});
         end
      end
      issued_total += int'(exp_rv);
      inflight_m    = exp_rv;
   endtask

   task automatic drain();
      int n = 0;
      while (!(aq.size() == 0 && issued_total == consumed) && n < 60) begin
         step(0, 0, 0, 1);
         n++;
      end
      check("drain_done", (aq.size() == 0 && issued_total == consumed), 1);
      step(0, 0, 0, 1);
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      cmd_v_i     = 1'b0;
      data_yumi_i = 1'b0;
      w_v_i       = 1'b0;
      #2;
      reset_i = 1'b1;
      #1;
      check("rst_cmd_ready", cmd_ready_o, 1);
      check("rst_r_v", r_v_o, 0);
      check("rst_r_addr", r_addr_o, 0);
      check("rst_data_v", data_v_o, 0);
      check("rst_data", data_o, 0);
      check("rst_last", data_last_o, 0);
      check("rst_busy", busy_o, 0);
      @(posedge clk_i);
      #2;
      reset_i = 1'b0;
      model_clear();
   endtask

   initial begin
      int base, n;
      for (int i = 0; i < ELS; i++) mem[i] = W'($urandom);

      pulse_reset();

      // Straight burst, then a wrapping burst.
      step(1, 3, 4, 1);
      drain();
      step(1, 6, 4, 1);
      drain();

      // Back-pressure: yumi withheld for 6 cycles.
      step(1, 1, 5, 0);
      base = issued_total;
      repeat (6) step(0, 0, 0, 0);
      check("bp_reads", issued_total - base, 2);
      drain();

      // Zero-length command is a no-op.
      step(1, 2, 0, 1);
      repeat (3) step(0, 0, 0, 1);

      // Reset mid-burst after two reads.
      step(1, 0, 6, 1);
      base = issued_total;
      n    = 0;
      while (issued_total - base < 2 && n < 20) begin
         step(0, 0, 0, 1);
         n++;
      end
      check("mid_reads", issued_total - base, 2);
      pulse_reset();
      step(1, 0, 1, 1);
      drain();
      check("post_rst_words", consumed, 1);

`ifdef BSG_MEM_STREAM_READER_COLLISION_STALL_EN
      // Write to the next read address stalls the read.
      step(1, 2, 4, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      coll_v    = 1;
      coll_addr = 4;
      base      = issued_total;
      repeat (3) step(0, 0, 0, 1);
      check("coll_stall", issued_total - base, 0);
      coll_v = 0;
      drain();
`endif

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         step(($urandom % 3) == 0, int'($urandom % ELS), int'($urandom % 7), ($urandom % 2) == 1);
         check("outstanding_le2", (issued_total - consumed) <= 2, 1);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
